// File: rtl/eac_pkg.sv
// eac_pkg: shared width, constants and op encoding for the modulo-(2^n-1) arithmetic blocks
package eac_pkg;
  localparam int EAC_WIDTH = 16;
  localparam logic [EAC_WIDTH-1:0] EAC_ALL_ONES = 16'hFFFF;
  typedef enum logic {EAC_OP_ADD = 1'b0, EAC_OP_SUB = 1'b1} eac_op_e;
endpackage

// File: rtl/eac_sub_pipe_core.sv
// eac_core: combinational end-around-carry adder; sum = g*2 + p folded modulo 2^WIDTH-1
module eac_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_g,
  input  logic [WIDTH-1:0] i_p,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_wrap
);
  logic [WIDTH:0] w_s;
  // g and p never share a set bit, so a+b = (g<<1) + p fits in WIDTH+1 bits
  assign w_s    = {i_g, 1'b0} + {1'b0, i_p};
  assign o_sum  = w_s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, w_s[WIDTH]};
  assign o_wrap = w_s[WIDTH];
endmodule

// File: rtl/eac_sub_pipe.sv
// eac_sub_pipe: 2-stage modulo-(2^16-1) add/subtract with valid/ready on both sides
// EAC_SUB_NORMALIZE_ZERO_EN: map a 0xFFFF result to the canonical 0x0000
module eac_sub_pipe
  import eac_pkg::*;
#(
  parameter int WIDTH = EAC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_zero,
  output logic             out_wrap
);
  logic             r_s1_valid, r_s2_valid, r_zero, r_wrap;
  logic [WIDTH-1:0] r_g, r_p, r_sum;
  logic [WIDTH-1:0] w_b, w_sum, w_res;
  logic             w_wrap, w_s1_adv, w_s2_adv;
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;
  assign w_b      = (in_op == EAC_OP_SUB) ? ~in_b : in_b;
  eac_core #(.WIDTH(WIDTH)) u_core (.i_g(r_g), .i_p(r_p), .o_sum(w_sum), .o_wrap(w_wrap));
`ifdef EAC_SUB_NORMALIZE_ZERO_EN
  assign w_res = (w_sum == EAC_ALL_ONES) ? '0 : w_sum;
`else
  assign w_res = w_sum;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_g        <= '0;
      r_p        <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_g <= in_a & w_b;
        r_p <= in_a ^ w_b;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_sum      <= '0;
      r_zero     <= 1'b0;
      r_wrap     <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum  <= w_res;
        r_zero <= (w_sum == '0) || (w_sum == EAC_ALL_ONES);
        r_wrap <= w_wrap;
      end
    end
  end
  assign out_valid = r_s2_valid;
  assign out_sum   = r_sum;
  assign out_zero  = r_zero;
  assign out_wrap  = r_wrap;
endmodule
